instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage of the emulated AVR core.
- Holds the PC and drives the flash word address. Assembles 16- and 32-bit instructions for the decoder.
- Computes the next PC through a 4-way next-PC multiplexer fed by this block's own select logic: sequential, relative branch, absolute jump/return, or hold.
- Sits directly upstream of the decoder and downstream of program memory.

Parameters:
- PC_WIDTH, 14, word-address width (16K words of flash); all PC arithmetic is modulo 2^PC_WIDTH.
- INSTR_WIDTH, 16, program memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_addr  out  PC_WIDTH  flash word address; equals the PC register.
- imem_data  in  INSTR_WIDTH  flash word at imem_addr, combinational same cycle.
- stall  in  1  freeze fetch (decoder or execute busy).
- branch_taken  in  1  relative redirect request.
- branch_offset  in  12  signed word offset (RJMP/RCALL/BRxx, pre-sign-extended to 12 bits).
- jump_valid  in  1  absolute redirect request (JMP/CALL/RET/IJMP).
- jump_target  in  PC_WIDTH  absolute target.
- instr_valid  out  1  instr_word/instr_pc valid this cycle.
- instr_word  out  2*INSTR_WIDTH  {first word, second word}; for a 16-bit instruction the upper half is 0.
- instr_is32  out  1  instr_word holds a two-word instruction.
- instr_pc  out  PC_WIDTH  address of the instruction's first word.

Behaviour:
- Reset (reset_n=0 at a clk edge): PC=0, state=FETCH, instr_valid=0, instr_word=0, instr_is32=0, instr_pc=0, internal first-word latch=0. Reset mid-FETCH2 discards the latched first word.
- States:
  - FETCH: read a single word, or the first word of a 32-bit instruction.
  - FETCH2: read the second word.
- Two-word detect on imem_data, any one of:
  - (w & 16'hFC0F)==16'h9000 (LDS/STS)
  - (w & 16'hFE0C)==16'h940C (JMP/CALL)
- Next-PC select (2-bit, priority order):
  - jump_valid → 2'b10 (jump_target).
  - branch_taken → 2'b01 (instr_pc + 1 + sext(branch_offset)).
  - stall → 2'b11 (PC, hold).
  - else → 2'b00 (PC + 1).
- Redirect (jump_valid or branch_taken) in any state, including under stall:
  - PC ← target; state ← FETCH; instr_valid ← 0 next cycle (one bubble).
  - A pending first word is dropped.
  - jump_valid beats branch_taken when both are asserted.
- Stall without redirect: PC, state, first-word latch and all output registers hold. instr_valid keeps its value; the decoder must not re-consume while stall=1.
- FETCH, no stall/redirect:
  - 16-bit instruction: instr_word ← {16'h0, imem_data}, instr_is32 ← 0, instr_pc ← PC, instr_valid ← 1, PC ← PC+1.
  - 32-bit instruction: first-word latch ← imem_data, PC ← PC+1, instr_valid ← 0, state ← FETCH2.
- FETCH2, no stall/redirect: instr_word ← {latch, imem_data}, instr_is32 ← 1, instr_pc ← PC−1, instr_valid ← 1, PC ← PC+1, state ← FETCH.
- Latency and throughput:
  - imem_addr to instr_valid is 1 cycle.
  - One 16-bit instruction per cycle; one 32-bit instruction per 2 cycles.
- Wrap-around: PC 2^PC_WIDTH−1 + 1 → 0. A 32-bit instruction at the last address takes its second word from address 0; instr_pc = last address. Relative targets wrap identically.

Decomposition:
- Shared package fetch_pkg:
  - state encoding FETCH/FETCH2.
  - next-PC select codes SEL_SEQ=2'b00, SEL_REL=2'b01, SEL_ABS=2'b10, SEL_HOLD=2'b11.
  - two-word opcode masks/values 16'hFC0F/16'h9000 and 16'hFE0C/16'h940C.
- One sub-module instance: multi_bit_multiplexer_4way #(PC_WIDTH) as the next-PC mux. A=seq, B=rel, C=abs, D=hold; S = select code above.
- Adders, detect logic and FSM stay in this module.

Test Plan:
- Reset: reset_n=0 for 2 cycles with random imem_data → imem_addr=0, instr_valid=0, all outputs 0. Release → imem_addr=0 on first cycle, 1 on next.
- Sequential: mem[0]=16'h0000, mem[1]=16'hE0A5 → valid cycles with instr_pc=0, 1; instr_word=32'h0000E0A5 on second; instr_is32=0.
- Two-word: mem[2]=16'h940C, mem[3]=16'h0123 → one bubble, then instr_word=32'h940C0123, instr_is32=1, instr_pc=2, imem_addr=4.
- Branch: branch_taken=1, branch_offset=12'hFFD while instr_pc=5 → next imem_addr=3, instr_valid=0 for one cycle.
- Priority: jump_valid=1 (target 14'h0100) with branch_taken=1 during FETCH2 → imem_addr=14'h0100, first word dropped, no instr_is32 output.
- Stall and wrap: stall=1 for 3 cycles → imem_addr and outputs frozen. Then PC=14'h3FFF holding 16'h9000 plus mem[0]=16'h0060 → instr_word=32'h90000060, instr_pc=14'h3FFF, imem_addr=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the AVR fetch stage:
// FSM states, next-PC select codes and two-word opcode patterns.
package fetch_pkg;

   typedef enum logic {
      FETCH  = 1'b0,
      FETCH2 = 1'b1
   } fetch_state_t;

   localparam logic [1:0] SEL_SEQ  = 2'b00;
   localparam logic [1:0] SEL_REL  = 2'b01;
   localparam logic [1:0] SEL_ABS  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   localparam logic [15:0] LDS_MASK = 16'hFC0F;
   localparam logic [15:0] LDS_VAL  = 16'h9000;
   localparam logic [15:0] JMP_MASK = 16'hFE0C;
   localparam logic [15:0] JMP_VAL  = 16'h940C;

   function automatic logic is_two_word(input logic [15:0] w);
      return ((w & LDS_MASK) == LDS_VAL) ||
             ((w & JMP_MASK) == JMP_VAL);
   endfunction

endpackage

// File: rtl/multi_bit_multiplexer_4way.sv
// Generic 4-input, WIDTH-bit multiplexer.
// S=00 selects A, 01 B, 10 C, 11 D.
module multi_bit_multiplexer_4way #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   input  logic [1:0]       i_s,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = i_a;
      unique case (i_s)
         2'b00: o_y = i_a;
         2'b01: o_y = i_b;
         2'b10: o_y = i_c;
         2'b11: o_y = i_d;
         default: o_y = i_a;
      endcase
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// AVR program counter and fetch stage: drives flash address,
// assembles one- and two-word instructions for the decoder.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_WIDTH    = 14,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic [PC_WIDTH-1:0]      imem_addr,
   input  logic [INSTR_WIDTH-1:0]   imem_data,
   input  logic                     stall,
   input  logic                     branch_taken,
   input  logic [11:0]              branch_offset,
   input  logic                     jump_valid,
   input  logic [PC_WIDTH-1:0]      jump_target,
   output logic                     instr_valid,
   output logic [2*INSTR_WIDTH-1:0] instr_word,
   output logic                     instr_is32,
   output logic [PC_WIDTH-1:0]      instr_pc
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [PC_WIDTH-1:0]      r_pc;
   logic [PC_WIDTH-1:0]      w_pc_nxt;
   logic [PC_WIDTH-1:0]      w_pc_seq;
   logic [PC_WIDTH-1:0]      w_pc_rel;
   logic [PC_WIDTH-1:0]      w_pc_prev;
   logic [PC_WIDTH-1:0]      w_off_ext;
   logic [1:0]               w_sel;
   logic                     w_redirect;
   logic                     w_two;

   logic [INSTR_WIDTH-1:0]   r_first;
   logic [INSTR_WIDTH-1:0]   w_first_nxt;
   logic                     r_valid;
   logic                     w_valid_nxt;
   logic [2*INSTR_WIDTH-1:0] r_word;
   logic [2*INSTR_WIDTH-1:0] w_word_nxt;
   logic                     r_is32;
   logic                     w_is32_nxt;
   logic [PC_WIDTH-1:0]      r_ipc;
   logic [PC_WIDTH-1:0]      w_ipc_nxt;

   assign w_off_ext = PC_WIDTH'($signed(branch_offset));
   assign w_pc_seq  = r_pc + PC_WIDTH'(1);
   assign w_pc_prev = r_pc - PC_WIDTH'(1);
   assign w_pc_rel  = r_ipc + PC_WIDTH'(1) + w_off_ext;
   assign w_redirect = jump_valid | branch_taken;
   assign w_two = is_two_word(imem_data[15:0]);

   always_comb begin
      w_sel = SEL_SEQ;
      if (jump_valid)
         w_sel = SEL_ABS;
      else if (branch_taken)
         w_sel = SEL_REL;
      else if (stall)
         w_sel = SEL_HOLD;
   end

   multi_bit_multiplexer_4way #(
      .WIDTH(PC_WIDTH)
   ) u_pc_mux (
      .i_a(w_pc_seq),
      .i_b(w_pc_rel),
      .i_c(jump_target),
      .i_d(r_pc),
      .i_s(w_sel),
      .o_y(w_pc_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_first_nxt = r_first;
      w_valid_nxt = r_valid;
      w_word_nxt  = r_word;
      w_is32_nxt  = r_is32;
      w_ipc_nxt   = r_ipc;
      if (w_redirect) begin
         // one bubble; any half-assembled instruction is dropped
         w_state_nxt = FETCH;
         w_valid_nxt = 1'b0;
      end else if (!stall) begin
         unique case (r_state)
            FETCH: begin
               if (w_two) begin
                  w_first_nxt = imem_data;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = FETCH2;
               end else begin
                  w_word_nxt  = {{INSTR_WIDTH{1'b0}}, imem_data};
                  w_is32_nxt  = 1'b0;
                  w_ipc_nxt   = r_pc;
                  w_valid_nxt = 1'b1;
               end
            end
            FETCH2: begin
               w_word_nxt  = {r_first, imem_data};
               w_is32_nxt  = 1'b1;
               w_ipc_nxt   = w_pc_prev;
               w_valid_nxt = 1'b1;
               w_state_nxt = FETCH;
            end
            default: w_state_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= FETCH;
         r_pc    <= '0;
         r_first <= '0;
         r_valid <= 1'b0;
         r_word  <= '0;
         r_is32  <= 1'b0;
         r_ipc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_first <= w_first_nxt;
         r_valid <= w_valid_nxt;
         r_word  <= w_word_nxt;
         r_is32  <= w_is32_nxt;
         r_ipc   <= w_ipc_nxt;
      end
   end

   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr_word  = r_word;
   assign instr_is32  = r_is32;
   assign instr_pc    = r_ipc;

endmodule
